// File: rtl/uart_module_mem_arb_pkg.sv
// Shared constants for the two-master on-chip RAM arbiter.
//   ARB_M0 / ARB_M1 : bit positions of each master in request/grant vectors
//   HOLD_W          : width of the consecutive-grant counter
//   be_width()      : byte-lane count for a given data width
package uart_module_mem_arb_pkg;

   localparam int unsigned ARB_M0 = 0;
   localparam int unsigned ARB_M1 = 1;
   localparam int unsigned HOLD_W = 4;

   function automatic int unsigned be_width(input int unsigned data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/uart_module_rr_arb2.sv
// Two-requester round-robin arbiter with a bounded hold.
//   clk, reset : clock, synchronous active-high reset
//   req        : request vector, bit ARB_M0 / ARB_M1
//   accept     : a granted transaction was taken this cycle
//   gnt        : one-hot grant, forced to zero while reset is high
// The last master granted keeps the grant under contention until it has
// been granted HOLD_MAX times in a row, then the other master gets it.
module uart_module_rr_arb2
   import uart_module_mem_arb_pkg::*;
#(
   parameter int unsigned HOLD_MAX = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt
);

   logic              last_grant_q, last_grant_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              keep;
   logic              winner;

   always_comb begin
      gnt  = 2'b00;
      // hold_cnt == 0 means nobody has been granted since reset, so nobody
      // holds: that is what lets m0 win the first contention.
      keep = req[last_grant_q] && (hold_cnt_q != '0) &&
             (hold_cnt_q < HOLD_W'(HOLD_MAX));
      if (!reset) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11: begin
               if (keep) gnt = last_grant_q ? 2'b10 : 2'b01;
               else      gnt = last_grant_q ? 2'b01 : 2'b10;
            end
            default: gnt = 2'b00;
         endcase
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      hold_cnt_d   = hold_cnt_q;
      winner       = gnt[ARB_M1];
      if (accept) begin
         if (winner != last_grant_q) begin
            last_grant_d = winner;
            hold_cnt_d   = HOLD_W'(1);
         end else if (hold_cnt_q != '1) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= 1'b1;
         hold_cnt_q   <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         hold_cnt_q   <= hold_cnt_d;
      end
   end

endmodule

// File: rtl/uart_module_onchip_mem_arbiter.sv
// Shares the single-port on-chip RAM between the Nios data master (m0) and
// the UART DMA engine (m1). Each master sees an Avalon-MM pipelined slave.
//   clk, reset       : clock, synchronous active-high reset
//   m0_* / m1_*      : per-master address/byteenable/read/write/writedata in,
//                      waitrequest/readdata/readdatavalid out
//   mem_*            : RAM address/byteenable/chipselect/write/writedata/clken
//                      out, readdata in (registered, 1-cycle latency)
// Requests pass to the RAM with no added latency; read data returns
// unregistered one cycle after acceptance to whichever master issued it.
module uart_module_onchip_mem_arbiter
   import uart_module_mem_arb_pkg::*;
#(
   parameter  int unsigned ADDR_W   = 15,
   parameter  int unsigned DATA_W   = 32,
   parameter  int unsigned HOLD_MAX = 4,
   localparam int unsigned BE_W     = be_width(DATA_W)
) (
   input  logic              clk,
   input  logic              reset,

   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,

   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,

   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata
);

   logic [1:0] req;
   logic [1:0] gnt;
   logic       accept;
   logic       rd_accept;
   logic       rd_pend_q, rd_pend_d;
   logic       rd_owner_q, rd_owner_d;

   assign req[ARB_M0] = m0_read | m0_write;
   assign req[ARB_M1] = m1_read | m1_write;

   uart_module_rr_arb2 #(
      .HOLD_MAX (HOLD_MAX)
   ) u_rr_arb2 (
      .clk    (clk),
      .reset  (reset),
      .req    (req),
      .accept (accept),
      .gnt    (gnt)
   );

   // Request path: straight mux from the granted master into the RAM.
   always_comb begin
      mem_clken      = 1'b1;
      mem_chipselect = |gnt;
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
      mem_write      = gnt[ARB_M0] & m0_write;
      if (gnt[ARB_M1]) begin
         mem_address    = m1_address;
         mem_byteenable = m1_byteenable;
         mem_writedata  = m1_writedata;
         mem_write      = m1_write;
      end
   end

   always_comb begin
      m0_waitrequest = reset | (req[ARB_M0] & ~gnt[ARB_M0]);
      m1_waitrequest = reset | (req[ARB_M1] & ~gnt[ARB_M1]);
      accept         = |(req & gnt);
      // Read+write together is a write, so it must not expect a response.
      rd_accept      = (gnt[ARB_M0] & m0_read & ~m0_write) |
                       (gnt[ARB_M1] & m1_read & ~m1_write);
      rd_pend_d      = rd_accept;
      rd_owner_d     = gnt[ARB_M1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_pend_q  <= 1'b0;
         rd_owner_q <= 1'b0;
      end else begin
         rd_pend_q  <= rd_pend_d;
         rd_owner_q <= rd_owner_d;
      end
   end

   // Gating with reset drops a read whose response would land in a reset cycle.
   always_comb begin
      m0_readdata      = mem_readdata;
      m1_readdata      = mem_readdata;
      m0_readdatavalid = rd_pend_q & ~rd_owner_q & ~reset;
      m1_readdatavalid = rd_pend_q &  rd_owner_q & ~reset;
   end

endmodule

// File: tb/tb_uart_module_onchip_mem_arbiter.sv
module tb_uart_module_onchip_mem_arbiter;

   localparam int unsigned ADDR_W = 15;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] m0_address, m1_address;
   logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
   logic              m0_read, m0_write, m1_read, m1_write;
   logic [DATA_W-1:0] m0_writedata, m1_writedata;
   logic              m0_waitrequest, m1_waitrequest;
   logic [DATA_W-1:0] m0_readdata, m1_readdata;
   logic              m0_readdatavalid, m1_readdatavalid;
   logic [ADDR_W-1:0] mem_address;
   logic [BE_W-1:0]   mem_byteenable;
   logic              mem_chipselect, mem_write, mem_clken;
   logic [DATA_W-1:0] mem_writedata;
   logic [DATA_W-1:0] mem_readdata;

   int n_cmp = 0;
   int n_err = 0;
   int proto_err = 0;

   always #5 clk = ~clk;

   uart_module_onchip_mem_arbiter dut (
      .clk              (clk),
      .reset            (reset),
      .m0_address       (m0_address),
      .m0_byteenable    (m0_byteenable),
      .m0_read          (m0_read),
      .m0_write         (m0_write),
      .m0_writedata     (m0_writedata),
      .m0_waitrequest   (m0_waitrequest),
      .m0_readdata      (m0_readdata),
      .m0_readdatavalid (m0_readdatavalid),
      .m1_address       (m1_address),
      .m1_byteenable    (m1_byteenable),
      .m1_read          (m1_read),
      .m1_write         (m1_write),
      .m1_writedata     (m1_writedata),
      .m1_waitrequest   (m1_waitrequest),
      .m1_readdata      (m1_readdata),
      .m1_readdatavalid (m1_readdatavalid),
      .mem_address      (mem_address),
      .mem_byteenable   (mem_byteenable),
      .mem_chipselect   (mem_chipselect),
      .mem_write        (mem_write),
      .mem_writedata    (mem_writedata),
      .mem_clken        (mem_clken),
      .mem_readdata     (mem_readdata)
   );

   // Single-port RAM stand-in: registered read, byte-lane writes.
   logic [DATA_W-1:0] ram [2**ADDR_W];
   always_ff @(posedge clk) begin
      if (mem_clken && mem_chipselect) begin
         if (mem_write) begin
            for (int b = 0; b < BE_W; b++)
               if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
         end else begin
            mem_readdata <= ram[mem_address];
         end
      end
   end

   // Protocol monitor: read and write together is illegal on the master side.
   always @(posedge clk) begin
      if (!reset && ((m0_read && m0_write) || (m1_read && m1_write))) begin
         proto_err <= proto_err + 1;
         $display("note: protocol error, read and write asserted together at %0t", $time);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1;
      tick();
      tick();
      reset = 0;
   endtask

   function automatic int winner(input int i);
      return (i / 4) % 2;
   endfunction

   initial begin
      int pulses;
      m0_address = '0; m1_address = '0; m0_byteenable = '0; m1_byteenable = '0;
      m0_writedata = '0; m1_writedata = '0;
      idle();
      reset = 1;
      tick();
      #1;
      check("rst_m0_wait", m0_waitrequest, 1);
      check("rst_m1_wait", m1_waitrequest, 1);
      check("rst_clken", mem_clken, 1);
      check("rst_m0_rdv", m0_readdatavalid, 0);
      check("rst_m1_rdv", m1_readdatavalid, 0);
      tick();
      reset = 0;
      #1;
      check("idle_cs", mem_chipselect, 0);

      // m0 write then read of 0x0010
      m0_write = 1; m0_address = 15'h0010; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
      #1;
      check("t1_wr_wait", m0_waitrequest, 0);
      check("t1_wr_memwr", mem_write, 1);
      check("t1_wr_addr", 32'(mem_address), 32'h10);
      tick();
      m0_write = 0; m0_read = 1;
      #1;
      check("t1_rd_wait", m0_waitrequest, 0);
      check("t1_wr_no_rdv", m0_readdatavalid, 0);
      tick();
      idle();
      #1;
      check("t1_m0_rdv", m0_readdatavalid, 1);
      check("t1_m0_data", m0_readdata, 32'hDEADBEEF);
      check("t1_m1_rdv", m1_readdatavalid, 0);
      tick();
      check("t1_rdv_once", m0_readdatavalid, 0);

      // preload 0x0020 via m1 and 0x7FFF via m0
      m1_write = 1; m1_address = 15'h0020; m1_writedata = 32'hCAFEF00D; m1_byteenable = 4'hF;
      #1;
      check("pre_m1_wait", m1_waitrequest, 0);
      tick();
      idle();
      m0_write = 1; m0_address = 15'h7FFF; m0_writedata = 32'hAABBCCDD; m0_byteenable = 4'hF;
      tick();
      idle();

      // Continuous contention: m0 x4, m1 x4, ...
      do_reset();
      m0_read = 1; m0_address = 15'h0010;
      m1_read = 1; m1_address = 15'h0020;
      for (int i = 0; i < 13; i++) begin
         if (i == 12) idle();
         #1;
         if (i < 12) begin
            check($sformatf("t2_m0_wait[%0d]", i), m0_waitrequest, winner(i) != 0);
            check($sformatf("t2_m1_wait[%0d]", i), m1_waitrequest, winner(i) != 1);
            check($sformatf("t2_cs[%0d]", i), mem_chipselect, 1);
         end
         if (i > 0) begin
            check($sformatf("t2_m0_rdv[%0d]", i), m0_readdatavalid, winner(i-1) == 0);
            check($sformatf("t2_m1_rdv[%0d]", i), m1_readdatavalid, winner(i-1) == 1);
            if (winner(i-1) == 0) check($sformatf("t2_m0_data[%0d]", i), m0_readdata, 32'hDEADBEEF);
            else                  check($sformatf("t2_m1_data[%0d]", i), m1_readdata, 32'hCAFEF00D);
         end
         tick();
      end

      // Simultaneous m0 write / m1 read of 0x7FFF, m0 first after reset
      do_reset();
      m0_write = 1; m0_address = 15'h7FFF; m0_writedata = 32'h12345678; m0_byteenable = 4'h3;
      m1_read = 1; m1_address = 15'h7FFF;
      #1;
      check("t3_m0_wait", m0_waitrequest, 0);
      check("t3_m1_wait", m1_waitrequest, 1);
      tick();
      m0_write = 0;
      #1;
      check("t3_m1_wait2", m1_waitrequest, 0);
      tick();
      idle();
      #1;
      check("t3_m1_rdv", m1_readdatavalid, 1);
      check("t3_m1_data", m1_readdata, 32'hAABB5678);
      tick();

      // Read accepted, reset in the next cycle drops it
      m1_read = 1; m1_address = 15'h0020;
      #1;
      check("t4_m1_wait", m1_waitrequest, 0);
      tick();
      idle();
      reset = 1;
      #1;
      check("t4_rst_m0_rdv", m0_readdatavalid, 0);
      check("t4_rst_m1_rdv", m1_readdatavalid, 0);
      check("t4_rst_m0_wait", m0_waitrequest, 1);
      tick();
      reset = 0;
      #1;
      check("t4_post_m1_rdv", m1_readdatavalid, 0);
      m0_read = 1; m1_read = 1;
      #1;
      check("t4_cont_m0_wait", m0_waitrequest, 0);
      check("t4_cont_m1_wait", m1_waitrequest, 1);
      tick();
      idle();
      tick();

      // m1 alone: 20 back-to-back reads
      pulses = 0;
      m1_address = 15'h0020;
      for (int i = 0; i < 21; i++) begin
         m1_read = (i < 20);
         #1;
         if (i < 20) check($sformatf("t5_m1_wait[%0d]", i), m1_waitrequest, 0);
         if (i > 0) begin
            check($sformatf("t5_m1_rdv[%0d]", i), m1_readdatavalid, 1);
            check($sformatf("t5_m1_data[%0d]", i), m1_readdata, 32'hCAFEF00D);
         end
         if (m1_readdatavalid) pulses++;
         check($sformatf("t5_m0_rdv[%0d]", i), m0_readdatavalid, 0);
         tick();
      end
      idle();
      #1;
      check("t5_tail_rdv", m1_readdatavalid, 0);
      check("t5_pulses", pulses, 20);

      // m0 read+write together behaves as a write
      m0_read = 1; m0_write = 1; m0_address = 15'h0030;
      m0_writedata = 32'h55AA55AA; m0_byteenable = 4'hF;
      #1;
      check("t6_wait", m0_waitrequest, 0);
      check("t6_memwr", mem_write, 1);
      tick();
      idle();
      #1;
      check("t6_no_rdv", m0_readdatavalid, 0);
      check("t6_proto_flag", proto_err, 1);
      m0_read = 1;
      tick();
      idle();
      #1;
      check("t6_rb_rdv", m0_readdatavalid, 1);
      check("t6_rb_data", m0_readdata, 32'h55AA55AA);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
